uart_rx: RTL and testbench

UART receiver. It recovers 8-bit LSB-first serial frames from the asynchronous `rx_in` line using the 16x oversampling `rx_tick` from the UART baud rate generator, and sits beside the UART transmitter inside the UART IP. Received bytes are presented with a one-cycle valid strobe, and error strobes flag framing and (optionally) parity faults.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync.sv | 18 +
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, oversampling and sample-point constants
package uart_pkg;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int SAMPLE_FIRST    = 7;
  localparam int SAMPLE_MID      = 8;
  localparam int SAMPLE_DECIDE   = 9;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } uart_state_e;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: STAGES-deep flop chain bringing an asynchronous bit into the clk domain
module uart_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  // shift the raw input through the chain, oldest sample at the top
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {STAGES{RST_VAL}};
    else sync_q <= STAGES'({sync_q, d_i});
  end
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver; define UART_RX_PARITY_EN for 8E1 framing (8N1 otherwise)
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_en,
  input  logic                 rx_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
  localparam uart_state_e AFTER_DATA = S_PARITY;
`else
  localparam uart_state_e AFTER_DATA = S_STOP;
`endif
  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_nx;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 valid_q, valid_d, ferr_q, ferr_d;
  logic                 line, wrap, decide, maj, last_bit;
`ifdef UART_RX_PARITY_EN
  logic                 pchk_q, pchk_d, perr_q, perr_d;
`endif

  uart_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(rx_in),
    .q_o(line)
  );

  assign wrap     = cnt_q == CW'(OVERSAMPLE - 1);
  assign cnt_nx   = wrap ? '0 : cnt_q + 1'b1;
  assign decide   = rx_tick && cnt_nx == CW'(SAMPLE_DECIDE);
  assign maj      = (smp_q[0] & smp_q[1]) | ((smp_q[0] | smp_q[1]) & line);
  assign last_bit = bit_q == BW'(DATA_BITS - 1);

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      smp_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pchk_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pchk_q  <= pchk_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // frame sequencing; a low stop bit parks in BREAK until the line idles again
  always_comb begin
    state_d = state_q;
    if (!uart_en) state_d = S_IDLE;
    else if (rx_tick)
      case (state_q)
        S_IDLE:   state_d = line ? S_IDLE : S_START;
        S_START:  state_d = decide && maj ? S_IDLE : wrap ? S_DATA : S_START;
        S_DATA:   state_d = wrap && last_bit ? AFTER_DATA : S_DATA;
        S_PARITY: state_d = wrap ? S_STOP : S_PARITY;
        S_STOP:   state_d = decide ? (maj ? S_IDLE : S_BREAK) : S_STOP;
        S_BREAK:  state_d = line ? S_IDLE : S_BREAK;
        default:  state_d = S_IDLE;
      endcase
  end

  // tick counter, 3-point sampling, shift register and result strobes
  always_comb begin
    cnt_d   = cnt_q;
    smp_d   = smp_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pchk_d  = pchk_q;
    perr_d  = 1'b0;
`endif
    if (!uart_en) begin
      cnt_d = '0;
      sh_d  = '0;
      bit_d = '0;
    end else if (rx_tick) begin
      cnt_d = state_q == S_IDLE ? '0 : cnt_nx;
      if (cnt_nx == CW'(SAMPLE_FIRST)) smp_d[0] = line;
      if (cnt_nx == CW'(SAMPLE_MID)) smp_d[1] = line;
      if (state_q == S_DATA && decide) sh_d = {maj, sh_q[DATA_BITS-1:1]};
      if (state_q == S_DATA && wrap) bit_d = last_bit ? '0 : bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
      if (state_q == S_PARITY && decide) pchk_d = ^{sh_q, maj};
`endif
      if (state_q == S_STOP && decide) begin
        valid_d = maj;
        ferr_d  = !maj;
        data_d  = maj ? sh_q : data_q;
`ifdef UART_RX_PARITY_EN
        perr_d  = maj & pchk_q;
`endif
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = state_q != S_IDLE;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus random frames checked against a frame-level receive model
module tb_uart_rx;
  logic       clk = 1'b0, rst = 1'b1, uart_en = 1'b1, rx_tick = 1'b0, rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, rx_busy;
  int         checks = 0, errors = 0;
  int         tick_n = 0, valid_tick = 0, t0 = 0;
  int         n_valid = 0, n_ferr = 0, n_perr = 0;
  int         e_valid = 0, e_ferr = 0, e_perr = 0;
  logic [7:0] got_q[$], exp_q[$];
  logic [7:0] last_data = 8'h00;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 169;
`else
  localparam int LAT = 153;
`endif

  uart_rx dut (
    .clk(clk),
    .rst(rst),
    .uart_en(uart_en),
    .rx_tick(rx_tick),
    .rx_in(rx_in),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (3) @(negedge clk);
    rx_tick = 1'b1;
    @(negedge clk);
    rx_tick = 1'b0;
  end

  always @(posedge clk) if (rx_tick) tick_n <= tick_n + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid <= n_valid + 1;
      got_q.push_back(rx_data);
      valid_tick <= tick_n;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (parity_err) n_perr <= n_perr + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!rx_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic bit_out(input logic b, input int n);
    rx_in = b;
    ticks(n);
  endtask

  // drive one frame; the model predicts the receiver's verdict from the frame content
  task automatic send(input logic [7:0] b, input logic par, input logic stop);
    t0 = tick_n;
    bit_out(1'b0, 16);
    for (int i = 0; i < 8; i++) bit_out(b[i], 16);
`ifdef UART_RX_PARITY_EN
    bit_out(par, 16);
    if (stop && ^{b, par}) e_perr++;
`else
    if (par === 1'bx) e_perr++;
`endif
    if (stop) begin
      e_valid++;
      exp_q.push_back(b);
      last_data = b;
    end else e_ferr++;
    bit_out(stop, 16);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_valid"}, n_valid, e_valid);
    chk({tag, "_ferr"}, n_ferr, e_ferr);
    chk({tag, "_perr"}, n_perr, e_perr);
  endtask

  task automatic chk_data(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) chk({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    repeat (4) @(negedge clk);
    chk("rst_busy", rx_busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    ticks(3);
    send(8'hA5, 1'b0, 1'b1);
    chk("a5_latency", valid_tick - (t0 + 1), LAT);
    chk_counts("a5");
    chk_data("a5");
    chk("a5_rx_data", rx_data, 8'hA5);
    chk("a5_busy", rx_busy, 1'b0);
    ticks(5);
    rx_in = 1'b0;
    ticks(4);
    rx_in = 1'b1;
    ticks(5);
    chk("glitch_busy_hi", rx_busy, 1'b1);
    ticks(1);
    chk("glitch_busy_lo", rx_busy, 1'b0);
    ticks(20);
    chk_counts("glitch");
    send(8'h00, 1'b0, 1'b0);
    bit_out(1'b0, 40 * 16);
    chk("break_busy", rx_busy, 1'b1);
    chk_counts("break");
    chk("break_rx_data", rx_data, last_data);
    bit_out(1'b1, 1);
    chk("break_idle", rx_busy, 1'b0);
    ticks(20);
    chk_counts("break_end");
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b0, 1'b1);
    chk_counts("par_bad");
    chk_data("par_bad");
    send(8'h07, 1'b1, 1'b1);
    chk_counts("par_good");
    chk_data("par_good");
`endif
    b = 8'h3C;
    bit_out(1'b0, 16);
    for (int i = 0; i < 4; i++) bit_out(b[i], 16);
    bit_out(b[4], 8);
    @(negedge clk);
    uart_en = 1'b0;
    @(negedge clk);
    chk("en_busy", rx_busy, 1'b0);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
    uart_en = 1'b1;
    ticks(20);
    chk_counts("en_abort");
    send(8'h3C, ^b, 1'b1);
    chk_counts("en_next");
    chk_data("en_next");
    send(8'h55, ^8'h55, 1'b1);
    send(8'hAA, ^8'hAA, 1'b1);
    chk_counts("b2b");
    chk_data("b2b");
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      bit_out(1'b1, $urandom_range(0, 20));
      send(b, 1'($urandom), 1'b1);
    end
    ticks(4);
    chk_counts("rand");
    chk_data("rand");
    chk("rand_rx_data", rx_data, last_data);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
